// File: rtl/keccak_squeezer.sv
// Streams the first DIGEST_BITS bits of a permuted Keccak state out as 64-bit lanes.
// Handshake: a word moves on a rising edge where out_valid and out_ready are both 1.
module keccak_squeezer #(
    parameter int DIGEST_BITS = 512,
    parameter bit BYTE_SWAP   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1599:0] state_in,
    input  logic          state_valid,
    output logic          state_ready,
    input  logic          flush,
    output logic [63:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy
);

    localparam int NW = DIGEST_BITS / 64;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NW - 1);

    generate
        if ((DIGEST_BITS % 64) != 0 || DIGEST_BITS < 64 || DIGEST_BITS > 1088) begin : g_bad_digest
            $error("keccak_squeezer: DIGEST_BITS must be a multiple of 64 in 64..1088");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [DIGEST_BITS-1:0] hold, hold_nx;
    logic [63:0]            word, word_swapped;
    logic                   xfer;

    // Lanes beyond the digest never leave the block.
    logic unused_upper;
    assign unused_upper = ^state_in[1599:DIGEST_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hold  <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hold_nx  = hold;
        xfer     = (state == SEND) && out_ready;
        case (state)
            IDLE: begin
                if (state_valid) begin
                    hold_nx  = state_in[DIGEST_BITS-1:0];
                    cnt_nx   = '0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (cnt == LAST_CNT) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        hold_nx = hold >> 64;
                        cnt_nx  = cnt + CW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // Abort wins over both capture and transfer; hold is left as it was.
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            hold_nx  = hold;
        end
    end

    always_comb begin
        word = hold[63:0];
        word_swapped = '0;
        for (int b = 0; b < 8; b++) begin
            word_swapped[8*b +: 8] = word[56-8*b +: 8];
        end
    end

    assign out_valid   = (state == SEND);
    assign busy        = (state == SEND);
    assign state_ready = (state == IDLE);
    assign out_last    = (state == SEND) && (cnt == LAST_CNT);
    assign out_data    = (state == SEND) ? (BYTE_SWAP ? word_swapped : word) : 64'h0;

endmodule

// File: tb/tb_keccak_squeezer.sv
// Directed bench for keccak_squeezer: 512-bit LE, 512-bit byte-swapped and 256-bit instances.
module tb_keccak_squeezer;

    localparam logic [63:0] STEP = 64'h0101010101010101;

    logic          clk;
    logic          rst_n;
    logic [1599:0] state_in;
    logic          state_valid, flush, out_ready;
    logic          state_ready0, out_valid0, out_last0, busy0;
    logic          state_ready1, out_valid1, out_last1, busy1;
    logic [63:0]   out_data0, out_data1;
    logic          state_valid2, out_ready2, flush2;
    logic          state_ready2, out_valid2, out_last2, busy2;
    logic [63:0]   out_data2;

    int n_total;
    int n_bad;
    logic [63:0] exp_q[$];

    keccak_squeezer #(.DIGEST_BITS(512), .BYTE_SWAP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .state_in(state_in), .state_valid(state_valid),
        .state_ready(state_ready0), .flush(flush), .out_data(out_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0), .busy(busy0)
    );

    keccak_squeezer #(.DIGEST_BITS(512), .BYTE_SWAP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .state_in(state_in), .state_valid(state_valid),
        .state_ready(state_ready1), .flush(flush), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1), .busy(busy1)
    );

    keccak_squeezer #(.DIGEST_BITS(256), .BYTE_SWAP(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .state_in(state_in), .state_valid(state_valid2),
        .state_ready(state_ready2), .flush(flush2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_lanes();
        for (int k = 0; k < 25; k++) state_in[64*k +: 64] = STEP * 64'(k);
    endtask

    task automatic capture();
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
    endtask

    initial begin
        logic [3:0]  pat;
        logic [63:0] held_word;
        logic        stalled;
        int          c;

        n_total = 0;
        n_bad   = 0;
        rst_n = 1'b0;
        state_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        state_valid2 = 1'b0; out_ready2 = 1'b0; flush2 = 1'b0;
        load_lanes();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_out_last", 64'(out_last0), 64'd0);
        check("rst_out_data", out_data0, 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_state_ready", 64'(state_ready0), 64'd1);
        rst_n = 1'b1;
        tick();

        // Single digest with out_ready high.
        capture();
        out_ready = 1'b1;
        check("send_state_ready", 64'(state_ready0), 64'd0);
        check("send_busy", 64'(busy0), 64'd1);
        for (int i = 0; i < 8; i++) begin
            check("d1_valid", 64'(out_valid0), 64'd1);
            check("d1_data", out_data0, STEP * 64'(i));
            check("d1_last", 64'(out_last0), (i == 7) ? 64'd1 : 64'd0);
            tick();
        end
        check("d1_ready_after", 64'(state_ready0), 64'd1);
        check("d1_valid_after", 64'(out_valid0), 64'd0);

        // Backpressure with out_ready pattern 1,0,0,1.
        for (int i = 0; i < 8; i++) exp_q.push_back(STEP * 64'(i));
        capture();
        pat = 4'b1001;
        stalled = 1'b0;
        held_word = '0;
        c = 0;
        while (exp_q.size() > 0 && c < 64) begin
            out_ready = pat[c % 4];
            #1;
            if (!out_valid0) begin
                check("bp_valid", 64'(out_valid0), 64'd1);
            end else begin
                if (stalled) check("bp_stable", out_data0, held_word);
                if (out_ready) begin
                    check("bp_word", out_data0, exp_q.pop_front());
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_word = out_data0;
                end
            end
            tick();
            c++;
        end
        check("bp_all_words", 64'(exp_q.size()), 64'd0);
        check("bp_idle_after", 64'(out_valid0), 64'd0);

        // Byte swap on lane 0.
        out_ready = 1'b0;
        state_in[63:0] = 64'h0011223344556677;
        capture();
        check("swap_data", out_data1, 64'h7766554433221100);
        check("noswap_data", out_data0, 64'h0011223344556677);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        load_lanes();

        // Flush after word 3, then flush colliding with capture.
        capture();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fl_data", out_data0, STEP * 64'(i));
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid0), 64'd0);
        check("fl_ready", 64'(state_ready0), 64'd1);
        flush = 1'b1;
        state_valid = 1'b1;
        tick();
        flush = 1'b0;
        state_valid = 1'b0;
        check("fl_no_capture", 64'(out_valid0), 64'd0);
        capture();
        check("fl_restart_valid", 64'(out_valid0), 64'd1);
        check("fl_restart_w0", out_data0, 64'd0);
        tick();
        check("fl_restart_w1", out_data0, STEP);
        repeat (7) tick();
        check("fl_drain_idle", 64'(state_ready0), 64'd1);

        // Asynchronous reset while word 2 is on the bus.
        capture();
        tick();
        tick();
        check("ar_pre_w2", out_data0, STEP * 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid0), 64'd0);
        check("ar_data", out_data0, 64'd0);
        check("ar_ready", 64'(state_ready0), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_spurious", 64'(out_valid0), 64'd0);
        end
        out_ready = 1'b0;

        // 256-bit instance with state_valid held high.
        out_ready2 = 1'b1;
        state_valid2 = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                check("d256_gap_valid", 64'(out_valid2), 64'd0);
                check("d256_gap_ready", 64'(state_ready2), 64'd1);
            end else begin
                check("d256_valid", 64'(out_valid2), 64'd1);
                check("d256_data", out_data2, STEP * 64'((i < 4) ? i : i - 5));
                check("d256_last", 64'(out_last2), (i == 3 || i == 8) ? 64'd1 : 64'd0);
            end
            tick();
        end
        state_valid2 = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/keccak_squeezer.md
Name: keccak_squeezer

Overview:
- Output-side counterpart to the absorb/padding front end.
- Accepts the 1600-bit Keccak state after the final permutation and streams the first DIGEST_BITS bits out as 64-bit lane words over a valid/ready handshake.
- Sits between the Keccak-f permutation core and the host or digest sink. Supports only digests that fit in one rate block, so no extra permutations are needed.

Parameters:
- DIGEST_BITS, 512, digest length in bits. Legal values: a multiple of 64, from 64 to 1088. Other values are rejected by an elaboration-time check.
- BYTE_SWAP, 0:
  - 0: each lane is emitted in Keccak little-endian byte order.
  - 1: bytes within each lane are reversed, for big-endian hex display.

Ports:
- clk  input  1  Single clock. All logic is rising-edge.
- rst_n  input  1  Asynchronous, active-low reset.
- state_in  input  1600  Permuted Keccak state. Lane k is state_in[64k+63:64k].
- state_valid  input  1  state_in holds a final state.
- state_ready  output  1  Block can accept a new state.
- flush  input  1  Synchronous abort of the current digest.
- out_data  output  64  Current digest word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  Sink accepts out_data.
- out_last  output  1  Current word is the final digest word.
- busy  output  1  A digest is in progress.

Behaviour:
- Derived values:
  - NW = DIGEST_BITS/64.
  - Word counter cnt has width clog2(NW), minimum 1 bit.
  - Holding register hold is DIGEST_BITS wide.
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; cnt=0; hold=0.
  - Outputs: out_valid=0, out_last=0, out_data=0, busy=0, state_ready=1.
- FSM states: IDLE and SEND.
- IDLE:
  - state_ready=1, out_valid=0.
  - On state_valid=1 at a clock edge: hold <= state_in[DIGEST_BITS-1:0], cnt <= 0, go to SEND.
  - Bits of state_in above DIGEST_BITS are ignored.
- SEND:
  - state_ready=0, out_valid=1, busy=1.
  - out_data = hold[63:0], byte-reversed if BYTE_SWAP=1.
  - out_last = (cnt == NW-1).
- Transfer: a transfer occurs on a clock edge where out_valid=1 and out_ready=1.
  - Not last word: hold shifts right by 64, cnt increments.
  - Last word: go to IDLE, cnt <= 0.
- Stall: with out_ready=0, out_data, out_last and cnt hold stable, and out_valid stays 1. The block never withdraws valid.
- Latency:
  - The first word is valid the cycle after state capture.
  - With out_ready held high, one word per cycle, NW cycles total.
  - state_ready returns to 1 the cycle after the last transfer, so back-to-back digests have one idle cycle between them.
- state_valid during SEND is ignored. The source must hold it until state_ready is seen.
- flush=1 at a clock edge:
  - Forces IDLE, cnt <= 0, and leaves hold unchanged.
  - Takes priority over a simultaneous transfer.
  - Takes priority over capture: with flush and state_valid in the same IDLE cycle, no capture occurs.
- Reset asserted mid-digest abandons the digest immediately. No partial words appear after reset release.
- NW=1: out_last=1 on the only word.
- combinational outputs: out_data, out_last, out_valid and state_ready are decoded from the registered FSM/hold/cnt only. There is no combinational path from out_ready or state_valid to any output.

Test Plan:
- Reset then single digest:
  - Stimulus: DIGEST_BITS=512, state_in lane k = 64'h0101010101010101*k, state_valid pulse, out_ready=1.
  - Required: eight words 0x0, 0x0101..01, … 0x0707..07 on consecutive cycles; out_last only on word 7; state_ready=1 on the following cycle.
- Backpressure:
  - Stimulus: same digest, out_ready toggled 1,0,0,1,…
  - Required: each word is held stable while out_ready=0, and no word is dropped or duplicated. Check with a scoreboard of 8 words.
- BYTE_SWAP=1:
  - Stimulus: lane0 = 64'h0011223344556677.
  - Required: first out_data = 64'h7766554433221100.
- Flush mid-stream:
  - Stimulus: flush asserted after word 3 has transferred.
  - Required: next cycle out_valid=0 and state_ready=1. A new state then restarts from lane 0.
- Async reset mid-digest:
  - Stimulus: rst_n pulled low between clock edges during word 2.
  - Required: out_valid=0 and out_data=0 immediately; after release, IDLE with no spurious output.
- DIGEST_BITS=256 with state_valid held high continuously:
  - Required: 4 words, then 1 idle cycle, then a new capture. Upper lanes are never emitted.
